// File: rtl/iob_eth_bd_arb_pkg.sv
// Shared types and helpers for the BD RAM arbiter.
package iob_eth_bd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_NREQ = 8;

  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Scanning downward leaves the lowest set index as the final assignment.
  function automatic logic [2:0] lowest_set(input logic [MAX_NREQ-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/iob_eth_bd_arb_sel.sv
// Combinational winner select for the BD arbiter.
// IOB_ETH_BD_ARB_RR_EN selects round-robin search from ptr_i+1; default is fixed priority.
module iob_eth_bd_arb_sel
  import iob_eth_bd_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_o,
  output logic             valid_o
);

  logic [NREQ-1:0] cand;

  assign cand    = req_i & ~mask_i;
  assign valid_o = |cand;

`ifdef IOB_ETH_BD_ARB_RR_EN
  // Walk offsets from far to near so the closest candidate after ptr_i wins.
  always_comb begin
    logic [31:0] pos;
    win_o = '0;
    pos   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      pos = 32'((int'(ptr_i) + i) % NREQ);
      if (cand[pos[IDX_W-1:0]]) win_o = pos[IDX_W-1:0];
    end
  end
`else
  logic unused_ptr;

  assign unused_ptr = ^ptr_i;
  assign win_o      = IDX_W'(lowest_set(MAX_NREQ'(cand)));
`endif

endmodule

// File: rtl/iob_eth_bd_arbiter.sv
// Locking request/grant arbiter sharing the single-port BD RAM, with hold-limit preemption.
// Define IOB_ETH_BD_ARB_RR_EN for round-robin winner selection instead of fixed priority.
module iob_eth_bd_arbiter
  import iob_eth_bd_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int BD_ADDR_W = 8,
  parameter int MAX_HOLD  = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*BD_ADDR_W-1:0] addr_i,
  input  logic [NREQ-1:0]           wen_i,
  input  logic [NREQ*32-1:0]        wdata_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      bd_en_o,
  output logic                      bd_wen_o,
  output logic [BD_ADDR_W-1:0]      bd_addr_o,
  output logic [31:0]               bd_o,
  input  logic [31:0]               bd_i
);

  localparam int IDX_W  = idx_width(NREQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [IDX_W-1:0]  ptr;

  logic [NREQ-1:0]   cur_onehot;
  logic [NREQ-1:0]   mask;
  logic              owner_req;
  logic              others_pending;
  logic              preempt;
  logic              access;
  logic [IDX_W-1:0]  win;
  logic              win_valid;

`ifdef IOB_ETH_BD_ARB_RR_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  assign ptr_d = (state_d == GRANT) ? cur_d : ptr_q;
  assign ptr   = ptr_q;
`else
  assign ptr = IDX_W'(NREQ - 1);
`endif

  assign cur_onehot     = NREQ'(1) << cur_q;
  assign mask           = (state_q == GRANT) ? cur_onehot : '0;
  assign owner_req      = req_i[cur_q];
  assign others_pending = |(req_i & ~cur_onehot);
  assign preempt        = (MAX_HOLD != 0) && (state_q == GRANT) && owner_req &&
                          (hold_q == HOLD_LAST) && others_pending;
  assign access         = |(gnt_q & req_i);

  iob_eth_bd_arb_sel #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_sel (
    .req_i  (req_i),
    .mask_i (mask),
    .ptr_i  (ptr),
    .win_o  (win),
    .valid_o(win_valid)
  );

  // A dropped or preempted owner hands over in the same cycle; the hold count
  // saturates so a lone owner is never evicted.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (win_valid) begin
          state_d = GRANT;
          cur_d   = win;
          gnt_d   = NREQ'(1) << win;
        end
      end
      GRANT: begin
        if (owner_req && !preempt) begin
          if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
        end else if (win_valid) begin
          cur_d  = win;
          gnt_d  = NREQ'(1) << win;
          hold_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign rvalid_d = (access && !wen_i[cur_q]) ? cur_onehot : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      gnt_q    <= '0;
      hold_q   <= '0;
      rvalid_q <= '0;
`ifdef IOB_ETH_BD_ARB_RR_EN
      ptr_q    <= IDX_W'(NREQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
`ifdef IOB_ETH_BD_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    bd_en_o   = 1'b0;
    bd_wen_o  = 1'b0;
    bd_addr_o = '0;
    bd_o      = '0;
    if (access) begin
      bd_en_o   = 1'b1;
      bd_wen_o  = wen_i[cur_q];
      bd_addr_o = addr_i[int'(cur_q)*BD_ADDR_W +: BD_ADDR_W];
      bd_o      = wdata_i[int'(cur_q)*32 +: 32];
    end
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = bd_i;

endmodule

// File: tb/tb_iob_eth_bd_arbiter.sv
// Directed self-checking bench for iob_eth_bd_arbiter with a 1-cycle-latency BD RAM model.
`timescale 1ns/1ps
module tb_iob_eth_bd_arbiter;

  localparam int NREQ      = 3;
  localparam int BD_ADDR_W = 8;
  localparam int MAX_HOLD  = 16;

  logic                      clk_i = 1'b0;
  logic                      arst_i;
  logic [NREQ-1:0]           req_i;
  logic [NREQ*BD_ADDR_W-1:0] addr_i;
  logic [NREQ-1:0]           wen_i;
  logic [NREQ*32-1:0]        wdata_i;
  logic [NREQ-1:0]           gnt_o;
  logic [NREQ-1:0]           rvalid_o;
  logic [31:0]               rdata_o;
  logic                      bd_en_o;
  logic                      bd_wen_o;
  logic [BD_ADDR_W-1:0]      bd_addr_o;
  logic [31:0]               bd_o;
  logic [31:0]               bd_i;

  logic [31:0] ram [256];
  int assert_count = 0;
  int fail_count   = 0;
  int hold_cycles;
  int bad_cycles;

  iob_eth_bd_arbiter #(
    .NREQ     (NREQ),
    .BD_ADDR_W(BD_ADDR_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .wen_i    (wen_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .bd_en_o  (bd_en_o),
    .bd_wen_o (bd_wen_o),
    .bd_addr_o(bd_addr_o),
    .bd_o     (bd_o),
    .bd_i     (bd_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port RAM with registered read data.
  always @(posedge clk_i) begin
    if (bd_en_o) begin
      if (bd_wen_o) ram[bd_addr_o] <= bd_o;
      bd_i <= ram[bd_addr_o];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setReq(input logic [NREQ-1:0] req);
    req_i = req;
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req, input int k, input logic [7:0] addr,
                               input logic wen, input logic [31:0] wdata);
    req_i                 = req;
    addr_i[k*8 +: 8]      = addr;
    wen_i[k]              = wen;
    wdata_i[k*32 +: 32]   = wdata;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[4]  = 32'h11223344;
    arst_i  = 1'b1;
    req_i   = '0;
    wen_i   = 3'b101;
    addr_i  = {8'hA2, 8'hA1, 8'hA0};
    wdata_i = {32'hBAD00002, 32'hBAD00001, 32'hBAD00000};

    // Reset state
    repeat (3) tick();
    checkOutput("rst_gnt", 32'(gnt_o), 32'h0);
    checkOutput("rst_rvalid", 32'(rvalid_o), 32'h0);
    checkOutput("rst_bd_en", 32'(bd_en_o), 32'h0);
    @(negedge clk_i);
    arst_i = 1'b0;
    tick();
    tick();

    // Single TX read: grant one cycle after request, data one cycle after access
    applyStimulus(3'b010, 1, 8'h04, 1'b0, 32'h0);
    checkOutput("t1_idle_gnt", 32'(gnt_o), 32'h0);
    checkOutput("t1_idle_en", 32'(bd_en_o), 32'h0);
    tick();
    checkOutput("t1_gnt", 32'(gnt_o), 32'h2);
    checkOutput("t1_en", 32'(bd_en_o), 32'h1);
    checkOutput("t1_wen", 32'(bd_wen_o), 32'h0);
    checkOutput("t1_addr", 32'(bd_addr_o), 32'h04);
    tick();
    checkOutput("t1_rvalid", 32'(rvalid_o), 32'h2);
    checkOutput("t1_rdata", rdata_o, 32'h11223344);
    setReq(3'b000);
    tick();
    checkOutput("t1_release_gnt", 32'(gnt_o), 32'h0);
    checkOutput("t1_release_rvalid", 32'(rvalid_o), 32'h0);

    // Simultaneous TX+RX, TX drops after three accesses
    applyStimulus(3'b110, 2, 8'h08, 1'b0, 32'h0);
    tick();
    checkOutput("t2_prio_gnt", 32'(gnt_o), 32'h2);
    tick();
    tick();
    tick();
    setReq(3'b100);
    checkOutput("t2_drop_en", 32'(bd_en_o), 32'h0);
    tick();
    checkOutput("t2_handover_gnt", 32'(gnt_o), 32'h4);
    checkOutput("t2_handover_addr", 32'(bd_addr_o), 32'h08);
    setReq(3'b000);
    tick();
    checkOutput("t2_idle_gnt", 32'(gnt_o), 32'h0);

    // Hold limit: TX preempted after 16 cycles while RX waits
    setReq(3'b110);
    tick();
    hold_cycles = 0;
    for (int i = 0; i < 60 && gnt_o == 3'b010; i++) begin
      hold_cycles++;
      tick();
    end
    checkOutput("t3_hold_cycles", 32'(hold_cycles), 32'd16);
    checkOutput("t3_rx_gnt", 32'(gnt_o), 32'h4);
    tick();
    tick();
    setReq(3'b010);
    tick();
    checkOutput("t3_regrant", 32'(gnt_o), 32'h2);
    setReq(3'b000);
    tick();
    checkOutput("t3_idle_gnt", 32'(gnt_o), 32'h0);

    // TX alone is never preempted; saturated count preempts as soon as RX arrives
    setReq(3'b010);
    tick();
    bad_cycles = 0;
    repeat (100) begin
      if (gnt_o !== 3'b010) bad_cycles++;
      tick();
    end
    checkOutput("t4_no_preempt", 32'(bad_cycles), 32'd0);
    setReq(3'b110);
    tick();
    checkOutput("t4_sat_preempt", 32'(gnt_o), 32'h4);
    setReq(3'b000);
    tick();

    // CPU write then TX read of the same word
    applyStimulus(3'b001, 0, 8'h10, 1'b1, 32'hDEADBEEF);
    applyStimulus(3'b001, 1, 8'h10, 1'b0, 32'h0);
    tick();
    checkOutput("t5_cpu_gnt", 32'(gnt_o), 32'h1);
    checkOutput("t5_wr_en", 32'(bd_en_o), 32'h1);
    checkOutput("t5_wr_wen", 32'(bd_wen_o), 32'h1);
    checkOutput("t5_wr_addr", 32'(bd_addr_o), 32'h10);
    checkOutput("t5_wr_data", bd_o, 32'hDEADBEEF);
    tick();
    checkOutput("t5_no_rvalid_a", 32'(rvalid_o), 32'h0);
    setReq(3'b010);
    tick();
    checkOutput("t5_no_rvalid_b", 32'(rvalid_o), 32'h0);
    checkOutput("t5_tx_gnt", 32'(gnt_o), 32'h2);
    checkOutput("t5_rd_addr", 32'(bd_addr_o), 32'h10);
    checkOutput("t5_rd_wen", 32'(bd_wen_o), 32'h0);
    tick();
    checkOutput("t5_rvalid", 32'(rvalid_o), 32'h2);
    checkOutput("t5_rdata", rdata_o, 32'hDEADBEEF);
    setReq(3'b000);
    tick();
    tick();

    // Reset while RX owns the RAM, then grant order from a full request set
    setReq(3'b100);
    tick();
    checkOutput("t6_rx_gnt", 32'(gnt_o), 32'h4);
    tick();
    checkOutput("t6_pre_rvalid", 32'(rvalid_o), 32'h4);
    arst_i = 1'b1;
    #1;
    checkOutput("t6_rst_gnt", 32'(gnt_o), 32'h0);
    checkOutput("t6_rst_rvalid", 32'(rvalid_o), 32'h0);
    checkOutput("t6_rst_en", 32'(bd_en_o), 32'h0);
    applyStimulus(3'b111, 0, 8'h20, 1'b0, 32'h0);
    tick();
    checkOutput("t6_rst_hold_gnt", 32'(gnt_o), 32'h0);
    checkOutput("t6_rst_hold_en", 32'(bd_en_o), 32'h0);
    @(negedge clk_i);
    arst_i = 1'b0;
    tick();
    checkOutput("t6_order0", 32'(gnt_o), 32'h1);
    setReq(3'b110);
    tick();
    checkOutput("t6_order1", 32'(gnt_o), 32'h2);
    setReq(3'b100);
    tick();
    checkOutput("t6_order2", 32'(gnt_o), 32'h4);
    setReq(3'b000);
    tick();
    checkOutput("t6_final_gnt", 32'(gnt_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
